// File: rtl/counter_pkg.sv
// Shared constants for the BCD counter bank: digit width,
// largest legal digit value and FSM state encodings.
package counter_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ADD  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/bcd_counter_bank_if.sv
// Control and display bundle between the trigger stage,
// the counter bank and the output stage.
interface bcd_counter_bank_if #(
    parameter int DIGITS = 6
);

    logic              inc;
    logic [DIGITS-1:0] inc_sel;
    logic              refresh;
    logic              clr;
    logic [4*DIGITS-1:0] count_q;
    logic              busy;
    logic              overflow;

    modport master (
        output inc, inc_sel, refresh, clr,
        input  count_q, busy, overflow
    );

    modport slave (
        input  inc, inc_sel, refresh, clr,
        output count_q, busy, overflow
    );

endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: q = d + s + ci, wrapped at ten.
// Inputs are legal BCD digits, so the raw sum never exceeds 11.
module bcd_digit_add
    import counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    input  logic               s,
    input  logic               ci,
    output logic [DIGIT_W-1:0] q,
    output logic               co
);

    logic [DIGIT_W-1:0] sum;

    always_comb begin
        sum = d + {{(DIGIT_W-1){1'b0}}, s}
                + {{(DIGIT_W-1){1'b0}}, ci};
        co  = (sum > BCD_MAX);
        q   = co ? (sum - 4'd10) : sum;
    end

endmodule

// File: rtl/bcd_counter_bank.sv
// Decimal counter bank: one digit added per clock with rippled carry;
// the displayed value only changes on refresh and never mid-carry.
module bcd_counter_bank
    import counter_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic clk,
    input  logic reset,
    bcd_counter_bank_if.slave bus
);

    localparam int IDX_W = $clog2(DIGITS) + 1;
    localparam int CW    = DIGIT_W * DIGITS;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     count_r;
    logic [DIGITS-1:0] mask;
    logic [IDX_W-1:0]  idx;
    logic              carry;
    logic              ref_pend;
    logic              ovf;

    logic [DIGIT_W-1:0] cur_d;
    logic               cur_s;
    logic [DIGIT_W-1:0] nxt_d;
    logic               nxt_c;
    logic               last;

    // Select the digit currently being processed
    always_comb begin
        cur_d = '0;
        cur_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_d = cnt[DIGIT_W*i +: DIGIT_W];
                cur_s = mask[i];
            end
        end
        last = (idx == IDX_W'(DIGITS-1));
    end

    bcd_digit_add u_add (
        .d  (cur_d),
        .s  (cur_s),
        .ci (carry),
        .q  (nxt_d),
        .co (nxt_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            count_r  <= '0;
            mask     <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            ref_pend <= 1'b0;
            ovf      <= 1'b0;
        end else if (bus.clr) begin
            state    <= IDLE;
            cnt      <= '0;
            count_r  <= '0;
            mask     <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            ref_pend <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.refresh)
                        count_r <= cnt;
                    if (bus.inc) begin
                        mask  <= bus.inc_sel;
                        idx   <= '0;
                        carry <= 1'b0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (bus.refresh)
                        ref_pend <= 1'b1;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IDX_W'(i))
                            cnt[DIGIT_W*i +: DIGIT_W] <= nxt_d;
                    end
                    carry <= nxt_c;
                    idx   <= idx + IDX_W'(1);
                    if (last) begin
                        if (nxt_c)
                            ovf <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ref_pend || bus.refresh) begin
                        count_r  <= cnt;
                        ref_pend <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.count_q  = count_r;
    assign bus.busy     = (state != IDLE);
    assign bus.overflow = ovf;

endmodule

// File: tb/tb_bcd_counter_bank.sv
// Directed bench for bcd_counter_bank with DIGITS=6.
module tb_bcd_counter_bank;

    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;
    int   n;

    always #5 clk = ~clk;

    bcd_counter_bank_if #(.DIGITS(6)) bus();

    bcd_counter_bank #(.DIGITS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag,
                       input logic [23:0] obs,
                       input logic [23:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse inc for one edge; returns just after that edge
    task automatic pulse_inc(input logic [5:0] sel);
        @(negedge clk);
        bus.inc     = 1'b1;
        bus.inc_sel = sel;
        @(negedge clk);
        bus.inc     = 1'b0;
        bus.inc_sel = '0;
    endtask

    task automatic inc_run(input logic [5:0] sel);
        pulse_inc(sel);
        repeat (7) @(negedge clk);
    endtask

    task automatic do_ref;
        @(negedge clk);
        bus.refresh = 1'b1;
        @(negedge clk);
        bus.refresh = 1'b0;
    endtask

    task automatic do_clr;
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask

    initial begin
        bus.inc     = 1'b0;
        bus.inc_sel = '0;
        bus.refresh = 1'b0;
        bus.clr     = 1'b0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_count", bus.count_q, 24'h000000);
        chk("rst_busy", 24'(bus.busy), 24'h0);
        chk("rst_ovf", 24'(bus.overflow), 24'h0);

        // Reset in the middle of an add
        inc_run(6'b000111);
        inc_run(6'b000011);
        inc_run(6'b000001);
        do_ref;
        chk("pre_rst_123", bus.count_q, 24'h000123);
        pulse_inc(6'b000001);
        @(negedge clk);
        chk("mid_add_busy", 24'(bus.busy), 24'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", bus.count_q, 24'h000000);
        chk("async_rst_busy", 24'(bus.busy), 24'h0);
        @(negedge clk);
        reset = 1'b0;
        do_ref;
        chk("post_rst_cnt", bus.count_q, 24'h000000);

        // Basic increment and busy length
        pulse_inc(6'b000001);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy) n++;
            @(negedge clk);
        end
        chk("busy_cycles", 24'(n), 24'd7);
        chk("no_ref_hold", bus.count_q, 24'h000000);
        do_ref;
        chk("basic_inc", bus.count_q, 24'h000001);

        // Carry ripple through several digits
        do_clr;
        for (int i = 0; i < 9; i++) inc_run(6'b000111);
        inc_run(6'b000001);
        do_ref;
        chk("ripple_1000", bus.count_q, 24'h001000);

        do_clr;
        for (int i = 0; i < 9; i++) inc_run(6'b000001);
        inc_run(6'b000011);
        do_ref;
        chk("multi_sel_20", bus.count_q, 24'h000020);

        // Overflow wrap and sticky flag
        do_clr;
        for (int i = 0; i < 9; i++) inc_run(6'b111111);
        do_ref;
        chk("all_nines", bus.count_q, 24'h999999);
        chk("ovf_before", 24'(bus.overflow), 24'h0);
        inc_run(6'b000001);
        do_ref;
        chk("wrap_zero", bus.count_q, 24'h000000);
        chk("ovf_set", 24'(bus.overflow), 24'h1);
        inc_run(6'b000001);
        do_ref;
        chk("ovf_sticky_cnt", bus.count_q, 24'h000001);
        chk("ovf_sticky", 24'(bus.overflow), 24'h1);
        do_clr;
        chk("clr_ovf", 24'(bus.overflow), 24'h0);
        chk("clr_count", bus.count_q, 24'h000000);

        // Refresh during ADD is deferred to DONE
        for (int i = 0; i < 9; i++) inc_run(6'b000011);
        do_ref;
        chk("pre_defer_99", bus.count_q, 24'h000099);
        pulse_inc(6'b000001);
        @(negedge clk);
        bus.refresh = 1'b1;
        @(negedge clk);
        bus.refresh = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("defer_hold_99", bus.count_q, 24'h000099);
            @(negedge clk);
        end
        chk("defer_done_100", bus.count_q, 24'h000100);
        chk("defer_idle", 24'(bus.busy), 24'h0);

        // Second inc while busy is dropped
        pulse_inc(6'b000001);
        @(negedge clk);
        pulse_inc(6'b000001);
        repeat (10) @(negedge clk);
        do_ref;
        chk("drop_busy_inc", bus.count_q, 24'h000101);

        // Clear during ADD with a pending refresh
        pulse_inc(6'b000001);
        bus.refresh = 1'b1;
        @(negedge clk);
        bus.refresh = 1'b0;
        bus.clr     = 1'b1;
        @(negedge clk);
        bus.clr     = 1'b0;
        chk("clr_add_busy", 24'(bus.busy), 24'h0);
        chk("clr_add_count", bus.count_q, 24'h000000);
        repeat (10) @(negedge clk);
        chk("clr_no_late_upd", bus.count_q, 24'h000000);
        do_ref;
        chk("clr_cnt_zero", bus.count_q, 24'h000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
